// File: rtl/coord_link_pkg.sv
// Shared definitions for the coordinate byte link: frame constants, the
// UART bit-level state encoding and the frame checksum.
package coord_link_pkg;

    // First byte of every frame, used as the default for the top-level HEADER.
    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

    // Header plus the four coordinate bytes, without the optional checksum.
    localparam int unsigned NBYTES_BASE = 5;

    // One 8N1 character on the wire: start bit, 8 data bits, stop bit.
    localparam int unsigned BITS_PER_BYTE = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Modulo-256 sum of the four coordinate bytes; the header is not included.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic [7:0] b4
    );
        return b1 + b2 + b3 + b4;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART 8N1 serialiser with its own baud counter.
// ready_o is high when idle or in the final cycle of the stop bit, so a load
// in that cycle chains the next character with no idle gap on the line.
module uart_byte_tx
    import coord_link_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign ready_o = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign tx_o    = tx_q;

    // Bit-level FSM: baud counting, shifting and the registered line level.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else if (load_i && ready_o) begin
            state_q <= START;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= byte_i;
            tx_q    <= 1'b0;
        end else begin
            if (state_q != IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/coord_frame_tx.sv
// Coordinate frame transmitter: snapshots d1..d4 on a send request and
// sends HEADER, d1, d2, d3, d4 as back-to-back UART 8N1 characters.
// Build option: define COORD_FRAME_CHECKSUM_EN to append a sixth byte,
// (d1+d2+d3+d4) mod 256 taken from the snapshot. BAUD_DIV must be >= 2.
module coord_frame_tx
    import coord_link_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 27000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned BAUD_DIV = CLK_HZ / BAUD,
    parameter logic [7:0]  HEADER   = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [7:0] d4,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef COORD_FRAME_CHECKSUM_EN
    localparam int unsigned NBYTES = NBYTES_BASE + 1;
`else
    localparam int unsigned NBYTES = NBYTES_BASE;
`endif
    localparam int unsigned IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic             busy_q;
    logic             done_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0][7:0]  snap_q;

    logic             accept;
    logic             next_byte;
    logic             frame_end;
    logic             uart_ready;
    logic             uart_load;
    logic [IDX_W-1:0] sel_idx;
    logic [7:0]       load_byte;

    // The done cycle also blocks acceptance, giving the one-cycle frame gap.
    assign accept    = start && !busy_q && !done_q;
    assign next_byte = busy_q && uart_ready && (idx_q != LAST_IDX);
    assign frame_end = busy_q && uart_ready && (idx_q == LAST_IDX);
    assign uart_load = accept || next_byte;
    assign sel_idx   = accept ? '0 : idx_q + IDX_W'(1);

    // Selects the byte handed to the serialiser on each load.
    // NOTE: default assignment first so no path leaves load_byte unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        load_byte = HEADER;
        case (sel_idx)
            IDX_W'(1): load_byte = snap_q[0];
            IDX_W'(2): load_byte = snap_q[1];
            IDX_W'(3): load_byte = snap_q[2];
            IDX_W'(4): load_byte = snap_q[3];
`ifdef COORD_FRAME_CHECKSUM_EN
            IDX_W'(5): load_byte = frame_checksum(snap_q[0], snap_q[1], snap_q[2], snap_q[3]);
`endif
            default:   load_byte = HEADER;
        endcase
    end

    // Frame sequencing: acceptance, snapshot, byte index, busy and done.
    // NOTE: the snapshot is reset with the control state; it is only four
    // bytes, and this keeps the outputs fully defined straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            snap_q <= '0;
        end else begin
            done_q <= frame_end;
            if (accept) begin
                busy_q <= 1'b1;
                idx_q  <= '0;
                snap_q <= {d4, d3, d2, d1};
            end else if (next_byte) begin
                idx_q <= idx_q + IDX_W'(1);
            end else if (frame_end) begin
                busy_q <= 1'b0;
                idx_q  <= '0;
            end
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (uart_load),
        .byte_i (load_byte),
        .ready_o(uart_ready),
        .tx_o   (tx)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_coord_frame_tx.sv
// Self-checking bench for coord_frame_tx at CLK_HZ=1000, BAUD=100 (10 clocks
// per bit). The expected line waveform is derived from the frame contents with
// plain arithmetic; works with or without COORD_FRAME_CHECKSUM_EN.
module tb_coord_frame_tx;

    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned BAUD   = 100;
    localparam int          D      = CLK_HZ / BAUD;
`ifdef COORD_FRAME_CHECKSUM_EN
    localparam int          NB     = 6;
`else
    localparam int          NB     = 5;
`endif
    localparam int          T      = NB * 10 * D;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] d1, d2, d3, d4;
    logic       tx, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    coord_frame_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .d1   (d1),
        .d2   (d2),
        .d3   (d3),
        .d4   (d4),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Sends one frame and checks it cycle by cycle. Called at a falling edge;
    // returns at the falling edge of the gap cycle following done.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input int chg_at,
                             input logic [7:0] a2, input logic [7:0] b2,
                             input logic [7:0] c2, input logic [7:0] d2n,
                             input bit hold, input string name);
        logic [7:0] fr[6];
        logic [7:0] rx;
        int glitch;
        int busy_bad;
        fr[0] = 8'hAA;
        fr[1] = a;
        fr[2] = b;
        fr[3] = c;
        fr[4] = d;
        fr[5] = 8'((int'(a) + int'(b) + int'(c) + int'(d)) % 256);
        glitch = 0;
        busy_bad = 0;
        rx = '0;
        d1 = a; d2 = b; d3 = c; d4 = d;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < T; k++) begin
            int j;
            int bi;
            logic e;
            j  = k / (10 * D);
            bi = (k % (10 * D)) / D;
            if (bi == 0) e = 1'b0;
            else if (bi == 9) e = 1'b1;
            else e = fr[j][bi - 1];
            if (tx !== e) glitch++;
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            if (k % D == D / 2) begin
                if (bi == 0) check($sformatf("%s startbit%0d", name, j), tx, 0);
                else if (bi == 9) begin
                    check($sformatf("%s stopbit%0d", name, j), tx, 1);
                    check($sformatf("%s byte%0d", name, j), rx, fr[j]);
                end else rx[bi - 1] = tx;
            end
            if (k == chg_at) begin
                d1 = a2; d2 = b2; d3 = c2; d4 = d2n;
            end
            @(negedge clk);
        end
        check({name, " tx_wave_errs"}, glitch, 0);
        check({name, " busy_errs"}, busy_bad, 0);
        check({name, " end_busy"}, busy, 0);
        check({name, " end_done"}, done, 1);
        check({name, " end_tx"}, tx, 1);
        @(negedge clk);
        check({name, " gap_busy"}, busy, 0);
        check({name, " gap_done"}, done, 0);
        check({name, " gap_tx"}, tx, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle busy", busy, 0);
        check("idle tx", tx, 1);

        // Inputs change mid-frame; the frame must carry the snapshot.
        run_frame(8'h00, 8'h96, 8'h01, 8'h2C, 50, 8'h01, 8'hF4, 8'h02, 8'h58, 1'b0, "iso");
        run_frame(8'h01, 8'hF4, 8'h02, 8'h58, -1, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, "next");

        // start held high across frames: one frame per gap, none in done cycle.
        for (int f = 0; f < 3; f++) begin
            logic [7:0] r1, r2, r3, r4;
            r1 = 8'($urandom); r2 = 8'($urandom);
            r3 = 8'($urandom); r4 = 8'($urandom);
            run_frame(r1, r2, r3, r4, 120 + f, 8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom), f != 2, $sformatf("hold%0d", f));
        end
        check("after hold busy", busy, 0);

        for (int f = 0; f < 2; f++) begin
            logic [7:0] r1, r2, r3, r4;
            r1 = 8'($urandom); r2 = 8'($urandom);
            r3 = 8'($urandom); r4 = 8'($urandom);
            run_frame(r1, r2, r3, r4, -1, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, $sformatf("rand%0d", f));
        end

        // Abort mid-frame with an asynchronous reset.
        d1 = 8'h12; d2 = 8'h34; d3 = 8'h56; d4 = 8'h78;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (237) @(negedge clk);
        check("pre-abort busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-abort tx", tx, 1);
        run_frame(8'h12, 8'h34, 8'h56, 8'h78, -1, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
